// File: rtl/hier_rr_dispatcher_if.sv
// Handshake bundle between an upstream token source, the dispatcher and its child fan-out.
// The master side drives tokens, child readies and credit returns; the slave side is the dispatcher.
interface hier_rr_dispatcher_if #(
  parameter int NUM_CHILD  = 15,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
);
  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_W-1:0]             in_data;
  logic [NUM_CHILD-1:0]          out_valid;
  logic [NUM_CHILD-1:0]          out_ready;
  logic [DATA_W-1:0]             out_data;
  logic [NUM_CHILD-1:0]          credit_ret;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;
  logic                          credit_err;

  modport master (
    output in_valid, in_data, out_ready, credit_ret,
    input  in_ready, out_valid, out_data, fifo_level, credit_err
  );

  modport slave (
    input  in_valid, in_data, out_ready, credit_ret,
    output in_ready, out_valid, out_data, fifo_level, credit_err
  );
endinterface

// File: rtl/hier_rr_dispatcher.sv
// Buffers upstream tokens and hands each to one child, picked round-robin among children
// that still hold credit. Offer register is a two-state FSM; credits are returned by children.
module hier_rr_dispatcher #(
  parameter int NUM_CHILD  = 15,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 2
) (
  input logic               clk,
  input logic               rst_n,
  hier_rr_dispatcher_if.slave bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CW    = $clog2(CREDITS + 1);
  localparam int IDX_W = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1;
  localparam logic [CW-1:0]    CRED_MAX  = CW'(CREDITS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CHILD - 1);
  localparam logic [IDX_W:0]   NUM_WIDE  = (IDX_W + 1)'(NUM_CHILD);

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  // ---------------- input FIFO ----------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              fifo_full, fifo_empty, push, pop;

  assign fifo_full     = (level == LVL_W'(FIFO_DEPTH));
  assign fifo_empty    = (level == '0);
  assign push          = bus.in_valid && !fifo_full;
  assign bus.in_ready  = !fifo_full;
  assign bus.fifo_level = level;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(push) - LVL_W'(pop);
    end
  end

  // NOTE: storage array is not reset; pointers and level define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  // ---------------- offer register state ----------------
  state_t               state_q, state_d;
  logic [NUM_CHILD-1:0] offer_q, offer_d;
  logic [IDX_W-1:0]     target_q, target_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic                 err_q;

  logic [CW-1:0]        credit_q [NUM_CHILD];
  logic [CW-1:0]        credit_d [NUM_CHILD];
  logic [NUM_CHILD-1:0] hs_vec, eligible, ret_err;
  logic                 hs, found, load;
  logic [IDX_W-1:0]     pick;

  assign bus.out_valid  = offer_q;
  assign bus.out_data   = data_q;
  assign bus.credit_err = err_q;

  // Only the offered child can complete a handshake; other readies are masked out.
  assign hs_vec = offer_q & bus.out_ready;
  assign hs     = |hs_vec;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    ret_err  = '0;
    eligible = '0;
    for (int i = 0; i < NUM_CHILD; i++) begin
      credit_d[i] = credit_q[i];
      case ({hs_vec[i], bus.credit_ret[i]})
        2'b10: credit_d[i] = credit_q[i] - CW'(1);
        2'b01: begin
          if (credit_q[i] == CRED_MAX) ret_err[i] = 1'b1;
          else                         credit_d[i] = credit_q[i] + CW'(1);
        end
        default: ;
      endcase
      eligible[i] = (credit_d[i] != '0);
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (hs) rr_d = (target_q == LAST_IDX) ? '0 : target_q + IDX_W'(1);
  end

  // Scan from the post-handshake pointer, wrapping, and take the first child with credit.
  always_comb begin
    logic [IDX_W:0] sum;
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int k = 0; k < NUM_CHILD; k++) begin
      sum = {1'b0, rr_d} + (IDX_W + 1)'(k);
      if (sum >= NUM_WIDE) sum = sum - NUM_WIDE;
      if (!found && eligible[sum[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = sum[IDX_W-1:0];
      end
    end
  end

  assign load = !fifo_empty && found && ((state_q == S_IDLE) || hs);
  assign pop  = load;

  always_comb begin
    state_d  = state_q;
    offer_d  = offer_q;
    target_d = target_q;
    data_d   = data_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d        = S_OFFER;
          offer_d        = '0;
          offer_d[pick]  = 1'b1;
          target_d       = pick;
          data_d         = mem[rd_ptr];
        end
      end
      S_OFFER: begin
        if (load) begin
          offer_d        = '0;
          offer_d[pick]  = 1'b1;
          target_d       = pick;
          data_d         = mem[rd_ptr];
        end else if (hs) begin
          state_d = S_IDLE;
          offer_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        offer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      offer_q  <= '0;
      target_q <= '0;
      data_q   <= '0;
      rr_q     <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < NUM_CHILD; i++) credit_q[i] <= CRED_MAX;
    end else begin
      state_q  <= state_d;
      offer_q  <= offer_d;
      target_q <= target_d;
      data_q   <= data_d;
      rr_q     <= rr_d;
      err_q    <= err_q | (|ret_err);
      for (int i = 0; i < NUM_CHILD; i++) credit_q[i] <= credit_d[i];
    end
  end

  a_offer_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_OFFER) |-> $onehot(offer_q));
  a_idle_quiet: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_IDLE) |-> (offer_q == '0));
endmodule
